sif_mc: RTL and testbench
=========================

# sif_mc

Parametrised multi-channel successor to the single-X/single-W storage interface. Holds one host-accessible X buffer (read/write) and NCH independently addressed W buffers (write-only from the host). A sequencer streams X[i] together with all NCH W[c][i] words over a valid/ready port to the downstream compute array. Sits between the host bus and the array datapath.

## Interface
- DW, 16: data word width
- DEPTH, 256: words per buffer (X and each W channel); power of two, ≥2
- NCH, 4: number of W channels, ≥1
- AW, $clog2(DEPTH): address width (derived, not overridden)
- CW, (NCH>1 ? $clog2(NCH) : 1): W channel-select width (derived)

- clk  in  1  single clock, all logic on rising edge
- rst_b  in  1  asynchronous, active-low reset
- xa_wr_s  in  1  X write strobe
- xa_rd_s  in  1  X read strobe
- xa_addr  in  AW  X address
- xa_data_wr  in  DW  X write data
- xa_data_rd  out  DW  X read data, registered
- wa_wr_s  in  1  W write strobe
- wa_ch  in  CW  W channel select
- wa_addr  in  AW  W address
- wa_data_wr  in  DW  W write data
- st_start  in  1  stream start pulse
- st_len  in  AW+1  number of beats to stream
- st_busy  out  1  sequencer active
- st_done  out  1  one-cycle completion pulse
- err_coll  out  1  one-cycle pulse: host write rejected during busy
- so_valid  out  1  stream beat valid
- so_ready  in  1  downstream accept
- so_x  out  DW  X[i]
- so_w  out  NCH*DW  W[c][i], channel c at bits [c*DW +: DW]
- so_last  out  1  final beat marker

## Operation
- Reset: all outputs 0; FSM IDLE; buffer contents undefined (not cleared).
- X read: xa_rd_s samples X[xa_addr] into xa_data_rd next cycle; xa_data_rd holds otherwise. Reads always allowed, also during busy.
- Simultaneous xa_wr_s and xa_rd_s, same address: read returns old data; write completes.
- W write: wa_wr_s writes W[wa_ch][wa_addr]; wa_ch ≥ NCH is ignored, no error.
- FSM states: IDLE, RUN.
- IDLE: st_start with st_len≠0 → RUN, idx=0, beat 0 loaded. st_len=0 → stay IDLE, st_done pulses next cycle. st_len>DEPTH clamped to DEPTH.
- RUN: so_valid=1, st_busy=1. On so_valid&&so_ready: if so_last → IDLE, so_valid=0, st_done=1 next cycle; else idx+1 and next beat loaded same edge.
- so_x/so_w/so_last stable while so_valid&&!so_ready.
- During RUN: host X/W writes discarded, err_coll pulses next cycle (once per rejected cycle); st_start ignored.
- Reset mid-RUN: immediate IDLE, so_valid=0, no st_done.

## Timing
- xa_data_rd latency: 1 cycle.
- Writes visible to streaming and reads the following cycle.
- st_start at edge N → so_valid and beat 0 at N+1.
- Throughput: one beat per cycle with so_ready held high; len beats occupy exactly len cycles of so_valid.
- st_done at cycle after final handshake; st_busy falls same cycle.

## Configuration
- SIF_ABORT_EN defined: adds input st_abort (1 bit). In RUN, st_abort → IDLE next cycle, so_valid=0, no st_done, err_coll not asserted. Abort and final handshake in same cycle: handshake wins, st_done pulses.
- Undefined: no st_abort port; stream runs to completion or reset only.

## Structure
- sif_pkg: state enum (IDLE, RUN), beat struct typedef (x, w array, last), err/done constants as needed.
- Sub-module sif_bank: DEPTH×DW register array, one write port, one combinational read port, one registered read port; instantiated 1 + NCH times (generate).
- sif_mc: FSM, index counter, host arbitration, output register.

## Test plan
- Write X[3]=0x1234, read X[3] → xa_data_rd=0x1234 one cycle after strobe; same-cycle write 0x5555/read addr 3 → returns 0x1234.
- Fill X[i]=i, W[c][i]=0x100*c+i (NCH=4), st_len=4, so_ready=1 → 4 consecutive beats, beat 2 so_x=2, so_w channel 3=0x302, so_last on beat 3, st_done one cycle later.
- Same stream, so_ready toggled 1,0,0,1 → data held stable while stalled; 4 beats total, no skip/duplicate.
- During RUN, wa_wr_s to W[1][0]=0xDEAD → err_coll pulse, later stream shows original W[1][0].
- st_len=0 → no so_valid, st_done one cycle after st_start; st_len=DEPTH+1 → DEPTH beats.
- SIF_ABORT_EN: st_abort at beat 1 of 4 → so_valid low next cycle, no st_done; rst_b low mid-RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/sif_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sif_pkg
// Description : Shared types for the multi-channel storage interface
//               (sif_mc). Holds the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sif_pkg;

    // Sequencer states: IDLE waits for st_start, RUN streams beats.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sif_bank.sv
`default_nettype none
// ============================================================================
// Module      : sif_bank
// Description : DEPTH x DW register-array buffer. One synchronous write port,
//               one combinational read port (stream side) and an optional
//               registered read port (host side, RD_REG=1).
// Ports       : clk, rst_b       - clock, async active-low reset
//               we/waddr/wdata   - write port
//               caddr/cdata      - combinational read port
//               re/raddr/rdata   - registered read port (holds when re=0)
// Revision    : 1.0 - initial release
// ============================================================================
module sif_bank #(
    parameter int DW     = 16,
    parameter int DEPTH  = 256,
    parameter bit RD_REG = 1'b1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] caddr,
    output logic [DW-1:0] cdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    // Storage is intentionally not reset; contents are undefined after reset.
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign cdata = r_mem[caddr];

    generate
        if (RD_REG) begin : g_rd_reg
            logic [DW-1:0] r_rdata;
            // Read samples the array before this edge's write lands, so a
            // same-address read/write returns the old word.
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    r_rdata <= '0;
                end else if (re) begin
                    r_rdata <= r_mem[raddr];
                end
            end
            assign rdata = r_rdata;
        end else begin : g_no_rd
            logic w_unused;
            assign w_unused = ^{re, raddr, rst_b};
            assign rdata    = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sif_mc.sv
`default_nettype none
// ============================================================================
// Module      : sif_mc
// Description : Multi-channel storage interface. One host read/write X buffer
//               plus NCH write-only W buffers; a sequencer streams X[i] with
//               all W[c][i] over a valid/ready port.
// Config      : define SIF_ABORT_EN to add the st_abort input.
// Ports       : clk, rst_b                    - clock, async active-low reset
//               xa_*                          - host X buffer access
//               wa_*                          - host W buffer write access
//               st_start/st_len/st_busy/st_done - stream control/status
//               st_abort (SIF_ABORT_EN only)  - stream abort
//               err_coll                      - host write rejected while busy
//               so_*                          - stream output (valid/ready)
// Revision    : 1.0 - initial release
// ============================================================================
module sif_mc #(
    parameter int DW    = 16,
    parameter int DEPTH = 256,
    parameter int NCH   = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              xa_wr_s,
    input  logic              xa_rd_s,
    input  logic [AW-1:0]     xa_addr,
    input  logic [DW-1:0]     xa_data_wr,
    output logic [DW-1:0]     xa_data_rd,
    input  logic              wa_wr_s,
    input  logic [CW-1:0]     wa_ch,
    input  logic [AW-1:0]     wa_addr,
    input  logic [DW-1:0]     wa_data_wr,
    input  logic              st_start,
`ifdef SIF_ABORT_EN
    input  logic              st_abort,
`endif
    input  logic [AW:0]       st_len,
    output logic              st_busy,
    output logic              st_done,
    output logic              err_coll,
    output logic              so_valid,
    input  logic              so_ready,
    output logic [DW-1:0]     so_x,
    output logic [NCH*DW-1:0] so_w,
    output logic              so_last
);
    import sif_pkg::*;

    typedef struct packed {
        logic [DW-1:0]     x;
        logic [NCH*DW-1:0] w;
        logic              last;
    } beat_t;

    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [AW-1:0]     r_idx;
    logic [AW-1:0]     r_last_idx;
    beat_t             r_beat;
    beat_t             w_beat_ld;
    logic              r_done;
    logic              r_err;

    logic              w_abort;
    logic              w_busy;
    logic              w_hs;
    logic              w_start_ok;
    logic              w_start_zero;
    logic [AW:0]       w_len_clamp;
    logic [AW-1:0]     w_len_m1;
    logic              w_load;
    logic [AW-1:0]     w_ld_addr;
    logic              w_ld_last;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_x_we;
    logic [NCH-1:0]    w_w_we;
    logic [DW-1:0]     w_x_c;
    logic [NCH*DW-1:0] w_w_c;
    logic [NCH*DW-1:0] w_unused_wrd;

`ifdef SIF_ABORT_EN
    assign w_abort = st_abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_busy       = (r_state == ST_RUN);
    assign w_hs         = w_busy && so_ready;
    assign w_len_clamp  = (st_len > c_DEPTH) ? c_DEPTH : st_len;
    assign w_len_m1     = AW'(w_len_clamp - 1'b1);
    assign w_start_ok   = !w_busy && st_start && (w_len_clamp != '0);
    assign w_start_zero = !w_busy && st_start && (st_len == '0);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok) w_state_nxt = ST_RUN;
            ST_RUN:  if ((w_hs && r_beat.last) || w_abort) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    // A beat is loaded from the combinational bank ports on the same edge
    // that starts the stream or accepts the previous beat.
    always_comb begin
        w_load     = 1'b0;
        w_ld_addr  = '0;
        w_ld_last  = 1'b0;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load     = w_start_ok;
                w_ld_last  = (w_len_m1 == '0);
                w_done_nxt = w_start_zero;
            end
            ST_RUN: begin
                // Final handshake beats abort: it still reports done.
                w_done_nxt = w_hs && r_beat.last;
                w_load     = w_hs && !r_beat.last && !w_abort;
                w_ld_addr  = r_idx + 1'b1;
                w_ld_last  = (w_ld_addr == r_last_idx);
            end
            default: ;
        endcase
    end

    assign w_err_nxt = w_busy && (xa_wr_s || wa_wr_s);
    assign w_beat_ld = '{x: w_x_c, w: w_w_c, last: w_ld_last};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_idx      <= '0;
            r_last_idx <= '0;
            r_beat     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_last_idx <= w_len_m1;
            end
            if (w_load) begin
                r_idx  <= w_ld_addr;
                r_beat <= w_beat_ld;
            end
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
        end
    end

    // ---------------- buffers ----------------
    // Host writes are only accepted while idle, so the streamed data is
    // frozen for the duration of a run.
    assign w_x_we = xa_wr_s && !w_busy;

    sif_bank #(.DW(DW), .DEPTH(DEPTH), .RD_REG(1'b1)) u_xbank (
        .clk   (clk),
        .rst_b (rst_b),
        .we    (w_x_we),
        .waddr (xa_addr),
        .wdata (xa_data_wr),
        .caddr (w_ld_addr),
        .cdata (w_x_c),
        .re    (xa_rd_s),
        .raddr (xa_addr),
        .rdata (xa_data_rd)
    );

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_wbank
            // Channel selects at or above NCH match no bank and are dropped.
            assign w_w_we[c] = wa_wr_s && !w_busy && (wa_ch == CW'(c));

            sif_bank #(.DW(DW), .DEPTH(DEPTH), .RD_REG(1'b0)) u_wbank (
                .clk   (clk),
                .rst_b (rst_b),
                .we    (w_w_we[c]),
                .waddr (wa_addr),
                .wdata (wa_data_wr),
                .caddr (w_ld_addr),
                .cdata (w_w_c[c*DW +: DW]),
                .re    (1'b0),
                .raddr ('0),
                .rdata (w_unused_wrd[c*DW +: DW])
            );
        end
    endgenerate

    // ---------------- outputs ----------------
    assign st_busy  = w_busy;
    assign so_valid = w_busy;
    assign st_done  = r_done;
    assign err_coll = r_err;
    assign so_x     = r_beat.x;
    assign so_w     = r_beat.w;
    assign so_last  = r_beat.last;

endmodule
`default_nettype wire

// File: tb/tb_sif_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_sif_mc
// Description : Scoreboard testbench for sif_mc. Stimulus pushes expected
//               beats into a queue; a negedge monitor compares every valid
//               cycle against the queue head and pops on handshake.
// Config      : define SIF_ABORT_EN to include the abort scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sif_mc;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int NCH   = 4;
    localparam int AW    = 4;
    localparam int CW    = 2;

    logic              clk = 1'b0;
    logic              rst_b = 1'b0;
    logic              xa_wr_s = 1'b0, xa_rd_s = 1'b0;
    logic [AW-1:0]     xa_addr = '0;
    logic [DW-1:0]     xa_data_wr = '0;
    logic [DW-1:0]     xa_data_rd;
    logic              wa_wr_s = 1'b0;
    logic [CW-1:0]     wa_ch = '0;
    logic [AW-1:0]     wa_addr = '0;
    logic [DW-1:0]     wa_data_wr = '0;
    logic              st_start = 1'b0;
    logic              st_abort = 1'b0;
    logic [AW:0]       st_len = '0;
    logic              st_busy, st_done, err_coll, so_valid, so_last;
    logic              so_ready = 1'b0;
    logic [DW-1:0]     so_x;
    logic [NCH*DW-1:0] so_w;

    sif_mc #(.DW(DW), .DEPTH(DEPTH), .NCH(NCH)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .xa_wr_s    (xa_wr_s),
        .xa_rd_s    (xa_rd_s),
        .xa_addr    (xa_addr),
        .xa_data_wr (xa_data_wr),
        .xa_data_rd (xa_data_rd),
        .wa_wr_s    (wa_wr_s),
        .wa_ch      (wa_ch),
        .wa_addr    (wa_addr),
        .wa_data_wr (wa_data_wr),
        .st_start   (st_start),
`ifdef SIF_ABORT_EN
        .st_abort   (st_abort),
`endif
        .st_len     (st_len),
        .st_busy    (st_busy),
        .st_done    (st_done),
        .err_coll   (err_coll),
        .so_valid   (so_valid),
        .so_ready   (so_ready),
        .so_x       (so_x),
        .so_w       (so_w),
        .so_last    (so_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]     x;
        logic [NCH*DW-1:0] w;
        logic              last;
    } beat_t;

    beat_t         exp_q[$];
    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] xm [DEPTH];
    logic [DW-1:0] wm [NCH][DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid cycle must match the queue head (also proves the
    // beat is held stable while stalled); pop on handshake.
    always @(negedge clk) begin
        if (rst_b && so_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL beat_unexpected: got x=%0h expected no beat", so_x);
            end else begin
                chk("beat_x", so_x, exp_q[0].x);
                chk("beat_w", so_w, exp_q[0].w);
                chk("beat_last", so_last, exp_q[0].last);
                if (so_ready) void'(exp_q.pop_front());
            end
        end
    end

    // All tasks start and end just after a rising edge.
    task automatic xwr(input int a, input logic [DW-1:0] d);
        xa_wr_s = 1'b1; xa_addr = AW'(a); xa_data_wr = d;
        @(posedge clk); #1 xa_wr_s = 1'b0;
        xm[a] = d;
    endtask

    task automatic wwr(input int c, input int a, input logic [DW-1:0] d);
        wa_wr_s = 1'b1; wa_ch = CW'(c); wa_addr = AW'(a); wa_data_wr = d;
        @(posedge clk); #1 wa_wr_s = 1'b0;
        wm[c][a] = d;
    endtask

    task automatic push_beats(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.x = xm[i];
            for (int c = 0; c < NCH; c++) b.w[c*DW +: DW] = wm[c][i];
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    // pat: so_ready per cycle, cyclic. coll: attempt W[1][0]=DEAD while busy.
    // full: so_ready constantly high, so latency and valid count are exact.
    task automatic run_stream(input int len, input logic [3:0] pat, input bit coll, input bit full);
        int  n;
        int  k;
        int  vcnt;
        bit  done;
        n = (len > DEPTH) ? DEPTH : len;
        push_beats(n);
        st_start = 1'b1; st_len = (AW+1)'(len); so_ready = pat[0];
        @(posedge clk); #1 st_start = 1'b0;
        k = 0; vcnt = 0; done = 1'b0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
            if (so_valid) vcnt++;
            if (coll && k == 3) chk("err_coll_pulse", err_coll, 1);
            if (coll && k == 4) chk("err_coll_clear", err_coll, 0);
            if (st_done) begin
                done = 1'b1;
                chk("busy_low_at_done", st_busy, 0);
            end else begin
                @(posedge clk); #1;
                so_ready = pat[k % 4];
                wa_wr_s  = coll && (k == 1);
                wa_ch = 2'd1; wa_addr = '0; wa_data_wr = 16'hDEAD;
            end
        end
        chk("done_seen", done, 1);
        if (full) begin
            chk("done_latency", k, n + 1);
            chk("valid_cycles", vcnt, n);
        end
        chk("queue_drained", exp_q.size(), 0);
        @(posedge clk); #1 so_ready = 1'b0; wa_wr_s = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", st_done, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- reset ----
        repeat (3) @(negedge clk);
        chk("rst_valid", so_valid, 0);
        chk("rst_busy", st_busy, 0);
        chk("rst_done", st_done, 0);
        chk("rst_err", err_coll, 0);
        chk("rst_rd", xa_data_rd, 0);
        chk("rst_so", {so_x, so_w, so_last}, 0);
        @(posedge clk); #1 rst_b = 1'b1;
        @(posedge clk); #1;

        // ---- host X access ----
        xwr(3, 16'h1234);
        xa_rd_s = 1'b1; xa_addr = 4'd3;
        @(posedge clk); #1 xa_rd_s = 1'b0;
        @(negedge clk);
        chk("x_read", xa_data_rd, 16'h1234);
        @(posedge clk); #1;
        xa_rd_s = 1'b1; xa_wr_s = 1'b1; xa_addr = 4'd3; xa_data_wr = 16'h5555;
        @(posedge clk); #1 xa_rd_s = 1'b0; xa_wr_s = 1'b0;
        @(negedge clk);
        chk("x_rw_old", xa_data_rd, 16'h1234);
        @(posedge clk); #1 xa_rd_s = 1'b1;
        @(posedge clk); #1 xa_rd_s = 1'b0;
        @(negedge clk);
        chk("x_rw_new", xa_data_rd, 16'h5555);
        @(negedge clk);
        chk("x_rd_hold", xa_data_rd, 16'h5555);
        @(posedge clk); #1;

        // ---- fill buffers ----
        for (int i = 0; i < DEPTH; i++) xwr(i, DW'(i));
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < DEPTH; i++) wwr(c, i, DW'(16'h100 * c + i));

        // ---- streams ----
        run_stream(4, 4'b1111, 1'b0, 1'b1);
        run_stream(4, 4'b1001, 1'b0, 1'b0);
        run_stream(4, 4'b1111, 1'b1, 1'b1);   // rejected write keeps W[1][0]=0x100
        run_stream(0, 4'b1111, 1'b0, 1'b1);
        run_stream(DEPTH + 1, 4'b1111, 1'b0, 1'b1);

        // ---- reset mid-run ----
        push_beats(8);
        st_start = 1'b1; st_len = 5'd8; so_ready = 1'b1;
        @(posedge clk); #1 st_start = 1'b0;
        @(posedge clk); #2 rst_b = 1'b0;
        #1;
        chk("rstrun_valid", so_valid, 0);
        chk("rstrun_busy", st_busy, 0);
        chk("rstrun_so", {so_x, so_w, so_last}, 0);
        chk("rstrun_done", st_done, 0);
        exp_q.delete();
        @(posedge clk); #1 rst_b = 1'b1; so_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rstrun_no_done", st_done, 0);
            chk("rstrun_idle", so_valid, 0);
        end
        @(posedge clk); #1;

`ifdef SIF_ABORT_EN
        // ---- abort at beat 1 of 4 ----
        push_beats(4);
        st_start = 1'b1; st_len = 5'd4; so_ready = 1'b1;
        @(posedge clk); #1 st_start = 1'b0;
        @(posedge clk); #1 st_abort = 1'b1;
        @(posedge clk); #1 st_abort = 1'b0; so_ready = 1'b0;
        @(negedge clk);
        chk("abort_valid", so_valid, 0);
        chk("abort_busy", st_busy, 0);
        chk("abort_no_done", st_done, 0);
        chk("abort_no_err", err_coll, 0);
        chk("abort_left", exp_q.size(), 2);
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done_later", st_done, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
